// File: rtl/bb_fetch_unit_pkg.sv
// Shared definitions for the bb_core fetch stage: default widths, reset PC
// and the fetch sequencer state encoding.
package bb_fetch_unit_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam logic [DATA_WIDTH-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/bb_fetch_unit.sv
// Program counter and single-outstanding instruction fetch for bb_core.
// Presents each fetched word with its PC and NPC; a redirect flushes the path.
module bb_fetch_unit
  import bb_fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = bb_fetch_unit_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_addr,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_gnt,
  input  logic                  i_imem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [DATA_WIDTH-1:0] o_inst_pc,
  output logic [DATA_WIDTH-1:0] o_npc
);

  localparam logic [DATA_WIDTH-1:0] ADDR_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  discard_q, discard_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [DATA_WIDTH-1:0] npc_q, npc_d;

  logic slot_free;
  logic imem_req;
  logic req_grant;

  // A new read is only issued when the output register is empty by the next edge,
  // so a response can never collide with an instruction still waiting on decode.
  assign slot_free = !inst_valid_q || i_inst_ready;
  assign imem_req  = (state_q == FETCH_REQ) && slot_free;
  assign req_grant = imem_req && i_imem_gnt;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    discard_d    = discard_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    npc_d        = npc_q;

    if (inst_valid_q && i_inst_ready) begin
      inst_valid_d = 1'b0;
    end

    unique case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (req_grant) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_ONE;
          state_d  = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (i_imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            inst_d       = i_imem_rdata;
            inst_pc_d    = req_pc_q;
            npc_d        = req_pc_q + ADDR_ONE;
            inst_valid_d = 1'b1;
          end
          state_d = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase

    // Redirect wins; if a read is still owed by memory we wait it out and drop it.
    if (i_redirect) begin
      pc_d         = i_redirect_addr;
      inst_valid_d = 1'b0;
      state_d      = FETCH_REQ;
      if (((state_q == FETCH_WAIT) && !i_imem_rvalid) || req_grant) begin
        discard_d = 1'b1;
        state_d   = FETCH_WAIT;
      end else if (state_q == FETCH_WAIT) begin
        discard_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      discard_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      npc_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      discard_q    <= discard_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      npc_q        <= npc_d;
    end
  end

  assign o_imem_req   = imem_req;
  assign o_imem_addr  = pc_q;
  assign o_inst_valid = inst_valid_q;
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;
  assign o_npc        = npc_q;

endmodule

// File: tb/tb_bb_fetch_unit.sv
// Self-checking bench for bb_fetch_unit: a randomized memory/decode environment
// checked against a transaction-level model of the expected instruction stream.
module tb_bb_fetch_unit;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_redirect;
  logic [DW-1:0] i_redirect_addr;
  logic          o_imem_req;
  logic [DW-1:0] o_imem_addr;
  logic          i_imem_gnt;
  logic          i_imem_rvalid;
  logic [DW-1:0] i_imem_rdata;
  logic          o_inst_valid;
  logic          i_inst_ready;
  logic [DW-1:0] o_inst;
  logic [DW-1:0] o_inst_pc;
  logic [DW-1:0] o_npc;

  always #5 clk = ~clk;

  bb_fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_redirect      (i_redirect),
    .i_redirect_addr (i_redirect_addr),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_gnt      (i_imem_gnt),
    .i_imem_rvalid   (i_imem_rvalid),
    .i_imem_rdata    (i_imem_rdata),
    .o_inst_valid    (o_inst_valid),
    .i_inst_ready    (i_inst_ready),
    .o_inst          (o_inst),
    .o_inst_pc       (o_inst_pc),
    .o_npc           (o_npc)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: next PC decode should see, and next PC memory should be asked for.
  logic [DW-1:0] exp_pc;
  logic [DW-1:0] fetch_pc;

  // Memory model: at most one read in flight.
  bit            pend;
  logic [DW-1:0] pend_addr;
  int            pend_delay;
  bit            force_rdata_en;
  logic [DW-1:0] force_rdata;
  bit            inject_rvalid;

  bit            prev_hold, prev_req, prev_gnt, prev_redir;
  logic [DW-1:0] prev_inst, prev_inst_pc, prev_npc, prev_addr;

  bit            last_req, last_grant, last_redir, last_valid, last_acc;
  logic [DW-1:0] last_addr, last_inst, last_inst_pc, last_acc_pc, last_acc_npc;
  int            valid_cycles;

  function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
    return (a ^ 16'h5A5A) + 16'h0101;
  endfunction

  task automatic clear_history();
    prev_hold = 0; prev_req = 0; prev_gnt = 0; prev_redir = 0;
    prev_inst = '0; prev_inst_pc = '0; prev_npc = '0; prev_addr = '0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    i_redirect = 1'b0;
    i_imem_gnt = 1'b0;
    i_imem_rvalid = 1'b0;
    i_inst_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    exp_pc = 16'h0000;
    fetch_pc = 16'h0000;
    pend = 0;
    pend_delay = 0;
    force_rdata_en = 0;
    inject_rvalid = 0;
    clear_history();
  endtask

  // One clock of environment: redir_mode 0 none, 1 now, 2 on req&gnt, 3 on rvalid.
  task automatic step(input int redir_mode, input logic [DW-1:0] tgt, input int gnt_pct,
                      input int ready_pct, input int lat_min, input int lat_max);
    bit rv;
    bit acc;
    bit grant;
    @(negedge clk);
    rst = 1'b0;
    if (prev_hold && !prev_redir) begin
      checks++;
      if (o_inst_valid !== 1'b1 || o_inst !== prev_inst || o_inst_pc !== prev_inst_pc ||
          o_npc !== prev_npc) begin
        errors++;
        $display("[TB] FAIL hold_stable: got valid=%b inst=%h pc=%h npc=%h, need valid=1 inst=%h pc=%h npc=%h",
                 o_inst_valid, o_inst, o_inst_pc, o_npc, prev_inst, prev_inst_pc, prev_npc);
      end
    end
    i_inst_ready = (int'($urandom_range(0, 99)) < ready_pct);
    i_redirect = (redir_mode == 1);
    i_redirect_addr = tgt;
    rv = pend && (pend_delay == 0);
    if (inject_rvalid) rv = 1;
    i_imem_rvalid = rv;
    if (inject_rvalid) i_imem_rdata = 16'hDEAD;
    else if (rv) i_imem_rdata = force_rdata_en ? force_rdata : mem_word(pend_addr);
    else i_imem_rdata = 16'($urandom);
    #1;
    i_imem_gnt = (int'($urandom_range(0, 99)) < gnt_pct);
    if (redir_mode == 2 && o_imem_req && i_imem_gnt) i_redirect = 1'b1;
    if (redir_mode == 3 && rv && pend) i_redirect = 1'b1;
    #1;
    if (prev_req && !prev_gnt && !prev_redir) begin
      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== prev_addr) begin
        errors++;
        $display("[TB] FAIL req_retry: got req=%b addr=%h, need req=1 addr=%h",
                 o_imem_req, o_imem_addr, prev_addr);
      end
    end
    if (o_imem_req === 1'b1) begin
      checks++;
      if (o_imem_addr !== fetch_pc || pend) begin
        errors++;
        $display("[TB] FAIL req_addr: got addr=%h outstanding=%b, need addr=%h outstanding=0",
                 o_imem_addr, pend, fetch_pc);
      end
    end
    if (o_inst_valid === 1'b1 && i_inst_ready === 1'b0) begin
      checks++;
      if (o_imem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL req_slot_busy: got req=%b, need 0", o_imem_req);
      end
    end
    acc = (o_inst_valid === 1'b1) && i_inst_ready;
    if (acc) begin
      checks++;
      if (o_inst_pc !== exp_pc || o_inst !== mem_word(exp_pc) || o_npc !== exp_pc + 16'd1) begin
        errors++;
        $display("[TB] FAIL inst_accept: got pc=%h inst=%h npc=%h, need pc=%h inst=%h npc=%h",
                 o_inst_pc, o_inst, o_npc, exp_pc, mem_word(exp_pc), exp_pc + 16'd1);
      end
      exp_pc = exp_pc + 16'd1;
    end
    grant = o_imem_req && i_imem_gnt;
    if (i_redirect) begin
      exp_pc = tgt;
      fetch_pc = tgt;
    end else if (grant) begin
      fetch_pc = fetch_pc + 16'd1;
    end
    if (rv && !inject_rvalid) pend = 0;
    else if (pend) pend_delay--;
    if (grant) begin
      pend = 1;
      pend_addr = o_imem_addr;
      pend_delay = $urandom_range(lat_min, lat_max);
    end
    prev_hold = (o_inst_valid === 1'b1) && !i_inst_ready;
    prev_inst = o_inst; prev_inst_pc = o_inst_pc; prev_npc = o_npc;
    prev_req = o_imem_req; prev_gnt = i_imem_gnt; prev_redir = i_redirect;
    prev_addr = o_imem_addr;
    last_req = o_imem_req; last_grant = grant; last_redir = i_redirect;
    last_valid = o_inst_valid; last_addr = o_imem_addr;
    last_inst = o_inst; last_inst_pc = o_inst_pc; last_acc = acc;
    last_acc_pc = o_inst_pc; last_acc_npc = o_npc;
    if (o_inst_valid === 1'b1) valid_cycles++;
  endtask

  task automatic wait_accept(input string name, input int budget, input int gnt_pct);
    int n;
    n = 0;
    last_acc = 0;
    while (!last_acc && n < budget) begin
      step(0, 16'h0, gnt_pct, 100, 0, 2);
      n++;
    end
    if (!last_acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no instruction in %0d cycles, need one", name, budget);
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (o_inst_valid !== 1'b0 || o_imem_req !== 1'b0 || o_inst !== 16'h0 || o_inst_pc !== 16'h0 ||
        o_npc !== 16'h0 || o_imem_addr !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b req=%b inst=%h pc=%h npc=%h addr=%h, need all 0",
               o_inst_valid, o_imem_req, o_inst, o_inst_pc, o_npc, o_imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] want;
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      want = 16'(k);
      wait_accept("stream", 10, 100);
      checks++;
      if (last_acc_pc !== want || last_acc_npc !== want + 16'd1) begin
        errors++;
        $display("[TB] FAIL stream_pc: got pc=%h npc=%h, need pc=%h npc=%h",
                 last_acc_pc, last_acc_npc, want, want + 16'd1);
      end
    end
    valid_cycles = 0;
    for (int k = 0; k < 20; k++) step(0, 16'h0, 100, 100, 0, 0);
    checks++;
    if (valid_cycles != 10) begin
      errors++;
      $display("[TB] FAIL stream_rate: got %0d valid cycles of 20, need 10", valid_cycles);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held_pc;
    int n;
    n = 0;
    last_valid = 0;
    while (!last_valid && n < 20) begin
      step(0, 16'h0, 100, 0, 0, 0);
      n++;
    end
    held_pc = last_inst_pc;
    for (int k = 0; k < 5; k++) begin
      step(0, 16'h0, 100, 0, 0, 0);
      checks++;
      if (last_valid !== 1'b1 || last_req !== 1'b0 || last_inst_pc !== held_pc) begin
        errors++;
        $display("[TB] FAIL bp_frozen: got valid=%b req=%b pc=%h, need valid=1 req=0 pc=%h",
                 last_valid, last_req, last_inst_pc, held_pc);
      end
    end
    step(0, 16'h0, 100, 100, 0, 0);
    checks++;
    if (last_req !== 1'b1 || last_acc !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got req=%b accept=%b, need req=1 accept=1", last_req, last_acc);
    end
  endtask

  task automatic test_gnt_stall();
    logic [DW-1:0] held_addr;
    int n;
    n = 0;
    last_req = 0;
    while (!last_req && n < 10) begin
      step(0, 16'h0, 0, 100, 0, 0);
      n++;
    end
    held_addr = last_addr;
    for (int k = 0; k < 3; k++) begin
      step(0, 16'h0, 0, 100, 0, 0);
      checks++;
      if (last_req !== 1'b1 || last_addr !== held_addr || last_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gnt_stall: got req=%b addr=%h valid=%b, need req=1 addr=%h valid=0",
                 last_req, last_addr, last_valid, held_addr);
      end
    end
    for (int k = 0; k < 6; k++) step(0, 16'h0, 100, 100, 0, 1);
  endtask

  task automatic test_redirect_wait();
    int n;
    bit saw_stale;
    n = 0;
    last_grant = 0;
    while (!last_grant && n < 10) begin
      step(0, 16'h0, 100, 100, 1, 1);
      n++;
    end
    force_rdata_en = 1;
    force_rdata = 16'hAAAA;
    step(1, 16'h0040, 100, 100, 1, 1);
    step(0, 16'h0, 0, 100, 0, 0);
    force_rdata_en = 0;
    saw_stale = 0;
    n = 0;
    last_acc = 0;
    while (!last_acc && n < 20) begin
      step(0, 16'h0, 100, 100, 0, 1);
      if (last_valid && last_inst == 16'hAAAA) saw_stale = 1;
      n++;
    end
    checks++;
    if (saw_stale || !last_acc || last_acc_pc !== 16'h0040 || last_acc_npc !== 16'h0041) begin
      errors++;
      $display("[TB] FAIL redirect_wait: got stale=%b accept=%b pc=%h npc=%h, need stale=0 accept=1 pc=0040 npc=0041",
               saw_stale, last_acc, last_acc_pc, last_acc_npc);
    end
  endtask

  task automatic test_redirect_edges();
    int n;
    n = 0;
    last_redir = 0;
    while (!last_redir && n < 20) begin
      step(2, 16'h0123, 100, 100, 0, 2);
      n++;
    end
    wait_accept("redir_gnt", 20, 100);
    checks++;
    if (!last_redir && n >= 20 || last_acc_pc !== 16'h0123) begin
      errors++;
      $display("[TB] FAIL redirect_on_grant: got pc=%h, need pc=0123", last_acc_pc);
    end
    n = 0;
    last_redir = 0;
    while (!last_redir && n < 20) begin
      step(3, 16'h0456, 100, 100, 0, 2);
      n++;
    end
    wait_accept("redir_rvalid", 20, 100);
    checks++;
    if (last_acc_pc !== 16'h0456) begin
      errors++;
      $display("[TB] FAIL redirect_on_rvalid: got pc=%h, need pc=0456", last_acc_pc);
    end
    step(1, 16'hFFFF, 100, 100, 0, 1);
    wait_accept("wrap_a", 20, 100);
    checks++;
    if (last_acc_pc !== 16'hFFFF || last_acc_npc !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL wrap_first: got pc=%h npc=%h, need pc=ffff npc=0000", last_acc_pc, last_acc_npc);
    end
    wait_accept("wrap_b", 20, 100);
    checks++;
    if (last_acc_pc !== 16'h0000 || last_acc_npc !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL wrap_second: got pc=%h npc=%h, need pc=0000 npc=0001", last_acc_pc, last_acc_npc);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    last_grant = 0;
    while (!last_grant && n < 10) begin
      step(0, 16'h0, 100, 100, 3, 3);
      n++;
    end
    do_reset(1);
    checks++;
    if (o_inst_valid !== 1'b0 || o_imem_req !== 1'b0 || o_imem_addr !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_state: got valid=%b req=%b addr=%h, need 0 0 0000",
               o_inst_valid, o_imem_req, o_imem_addr);
    end
    inject_rvalid = 1;
    step(0, 16'h0, 0, 100, 0, 0);
    step(0, 16'h0, 0, 100, 0, 0);
    inject_rvalid = 0;
    step(0, 16'h0, 0, 100, 0, 0);
    checks++;
    if (last_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL late_rvalid: got valid=%b inst=%h, need valid=0", last_valid, last_inst);
    end
    wait_accept("reset_mid", 20, 100);
    checks++;
    if (last_acc_pc !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_first: got pc=%h, need pc=0000", last_acc_pc);
    end
  endtask

  task automatic test_random();
    int mode;
    int r;
    for (int k = 0; k < 500; k++) begin
      r = int'($urandom_range(0, 99));
      mode = (r < 4) ? 1 : (r < 7) ? 2 : (r < 10) ? 3 : 0;
      step(mode, 16'($urandom), 60, 70, 0, 3);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_redirect = 1'b0;
    i_redirect_addr = '0;
    i_imem_gnt = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata = '0;
    i_inst_ready = 1'b0;
    force_rdata = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect_wait();
    test_redirect_edges();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by 500000, need finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
